// File: rtl/spi_flash_responder.sv
// SPI-flash target emulator: oversamples a mode-0 SPI link and serves reads from a sync memory port.
// Define SPI_FLASH_RESPONDER_WRITE_EN to add WREN/WRDI/page-program and the mem_wr/mem_wdata ports.
module spi_flash_responder #(
    parameter int unsigned ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk_48mhz,
    input  logic              reset,
    input  logic              spi_cs,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
`endif
    output logic              powered_down
);

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_DP   = 8'hB9;
    localparam logic [7:0] CMD_RES  = 8'hAB;
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_WRDI = 8'h04;
    localparam logic [7:0] CMD_PP   = 8'h02;
`endif

    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_ID, ST_STATUS, ST_PD, ST_IGNORE, ST_PROG
    } state_t;

    state_t              state_q, state_d;
    logic                cs_meta_q, cs_meta_d, cs_s_q, cs_s_d;
    logic                sck_meta_q, sck_meta_d, sck_s_q, sck_s_d, sck_prev_q, sck_prev_d;
    logic                mosi_meta_q, mosi_meta_d, mosi_s_q, mosi_s_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d, id_idx_q, id_idx_d;
    logic [6:0]          shift_q, shift_d;
    logic [22:0]         addr_sh_q, addr_sh_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                miso_q, miso_d, oe_q, oe_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d, rd_dly_q, rd_dly_d;
    logic                pd_q, pd_d;
    logic                wel_c;
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
    logic                wel_q, wel_d, wel_set_q, wel_set_d, wel_clr_q, wel_clr_d;
    logic                is_write_q, is_write_d, mem_wr_q, mem_wr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    assign wel_c = wel_q;
`else
    assign wel_c = 1'b0;
`endif

    logic       rise_c, fall_c;
    logic [7:0] rx_byte_c, cur_byte_c, id_byte_c, status_byte_c;
    logic [23:0] addr_full_c;

    assign rise_c        = sck_s_q & ~sck_prev_q;
    assign fall_c        = ~sck_s_q & sck_prev_q;
    assign rx_byte_c     = {shift_q, mosi_s_q};
    assign addr_full_c   = {addr_sh_q, mosi_s_q};
    // Read data may arrive in the very clk of the first fall, so bypass the byte register then.
    assign cur_byte_c    = rd_dly_q ? mem_rdata : tx_byte_q;
    assign status_byte_c = {6'd0, wel_c, 1'b0};

    always_comb begin
        case (id_idx_q)
            2'd0:    id_byte_c = JEDEC_ID[23:16];
            2'd1:    id_byte_c = JEDEC_ID[15:8];
            default: id_byte_c = JEDEC_ID[7:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cs_meta_d   = spi_cs;
        cs_s_d      = cs_meta_q;
        sck_meta_d  = spi_sck;
        sck_s_d     = sck_meta_q;
        sck_prev_d  = sck_s_q;
        mosi_meta_d = spi_mosi;
        mosi_s_d    = mosi_meta_q;
        bit_cnt_d   = bit_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        id_idx_d    = id_idx_q;
        shift_d     = shift_q;
        addr_sh_d   = addr_sh_q;
        tx_byte_d   = rd_dly_q ? mem_rdata : tx_byte_q;
        miso_d      = miso_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        rd_dly_d    = mem_rd_q;
        pd_d        = pd_q;
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
        wel_d       = wel_q;
        wel_set_d   = wel_set_q;
        wel_clr_d   = wel_clr_q;
        is_write_d  = is_write_q;
        mem_wr_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
`endif
        if (cs_s_q) begin
            state_d    = ST_IDLE;
            miso_d     = 1'b0;
            bit_cnt_d  = 3'd0;
            tx_cnt_d   = 3'd0;
            byte_cnt_d = 2'd0;
            id_idx_d   = 2'd0;
            if (state_q == ST_PD) pd_d = 1'b1;
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
            if (wel_set_q) wel_d = 1'b1;
            if (wel_clr_q) wel_d = 1'b0;
            wel_set_d  = 1'b0;
            wel_clr_d  = 1'b0;
            is_write_d = 1'b0;
`endif
        end else begin
            if (rise_c && state_q != ST_IDLE) begin
                shift_d   = rx_byte_c[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            case (state_q)
                ST_IDLE: state_d = ST_CMD;
                ST_CMD: begin
                    if (rise_c && bit_cnt_q == 3'd7) begin
                        state_d    = ST_IGNORE;
                        byte_cnt_d = 2'd0;
                        if (rx_byte_c == CMD_RES) begin
                            pd_d = 1'b0;
                        end else if (!pd_q) begin
                            case (rx_byte_c)
                                CMD_READ: state_d = ST_ADDR;
                                CMD_RDID: state_d = ST_ID;
                                CMD_RDSR: state_d = ST_STATUS;
                                CMD_DP:   state_d = ST_PD;
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
                                CMD_WREN: wel_set_d = 1'b1;
                                CMD_WRDI: wel_clr_d = 1'b1;
                                CMD_PP: begin
                                    wel_clr_d = 1'b1;
                                    if (wel_q) begin
                                        state_d    = ST_ADDR;
                                        is_write_d = 1'b1;
                                    end
                                end
`endif
                                default: state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise_c) begin
                        addr_sh_d = addr_full_c[22:0];
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd2) begin
                                mem_addr_d = ADDR_W'(addr_full_c);
                                tx_cnt_d   = 3'd0;
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
                                if (is_write_q) begin
                                    state_d = ST_PROG;
                                end else begin
                                    state_d  = ST_DATA;
                                    mem_rd_d = 1'b1;
                                end
`else
                                state_d  = ST_DATA;
                                mem_rd_d = 1'b1;
`endif
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (fall_c) begin
                        miso_d   = cur_byte_c[3'd7 - tx_cnt_q];
                        tx_cnt_d = tx_cnt_q + 3'd1;
                        if (tx_cnt_q == 3'd7) begin
                            mem_addr_d = mem_addr_q + ADDR_W'(1);
                            mem_rd_d   = 1'b1;
                        end
                    end
                end
                ST_ID: begin
                    if (fall_c) begin
                        miso_d   = id_byte_c[3'd7 - tx_cnt_q];
                        tx_cnt_d = tx_cnt_q + 3'd1;
                        if (tx_cnt_q == 3'd7) id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                    end
                end
                ST_STATUS: begin
                    if (fall_c) begin
                        miso_d   = status_byte_c[3'd7 - tx_cnt_q];
                        tx_cnt_d = tx_cnt_q + 3'd1;
                    end
                end
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
                ST_PROG: begin
                    // Page program wraps within the 256-byte page.
                    if (mem_wr_q) mem_addr_d[7:0] = mem_addr_q[7:0] + 8'd1;
                    if (rise_c && bit_cnt_q == 3'd7) begin
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = rx_byte_c;
                    end
                end
`endif
                default: miso_d = 1'b0;
            endcase
        end
        oe_d = (state_d == ST_DATA) || (state_d == ST_ID) || (state_d == ST_STATUS);
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cs_meta_q   <= 1'b1;
            cs_s_q      <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_s_q     <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_s_q    <= 1'b0;
            bit_cnt_q   <= 3'd0;
            tx_cnt_q    <= 3'd0;
            byte_cnt_q  <= 2'd0;
            id_idx_q    <= 2'd0;
            shift_q     <= 7'd0;
            addr_sh_q   <= 23'd0;
            tx_byte_q   <= 8'd0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            rd_dly_q    <= 1'b0;
            pd_q        <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
            wel_q       <= 1'b0;
            wel_set_q   <= 1'b0;
            wel_clr_q   <= 1'b0;
            is_write_q  <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cs_meta_q   <= cs_meta_d;
            cs_s_q      <= cs_s_d;
            sck_meta_q  <= sck_meta_d;
            sck_s_q     <= sck_s_d;
            sck_prev_q  <= sck_prev_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_s_q    <= mosi_s_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            id_idx_q    <= id_idx_d;
            shift_q     <= shift_d;
            addr_sh_q   <= addr_sh_d;
            tx_byte_q   <= tx_byte_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            rd_dly_q    <= rd_dly_d;
            pd_q        <= pd_d;
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
            wel_q       <= wel_d;
            wel_set_q   <= wel_set_d;
            wel_clr_q   <= wel_clr_d;
            is_write_q  <= is_write_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
`endif
        end
    end

    assign spi_miso     = miso_q;
    assign spi_miso_oe  = oe_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign powered_down = pd_q;
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
    assign mem_wr       = mem_wr_q;
    assign mem_wdata    = mem_wdata_q;
`endif

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: a mode-0 SPI master task plus a registered memory model.
module tb_spi_flash_responder;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned HALF   = 120;

    logic              clk_48mhz = 1'b0;
    logic              reset;
    logic              spi_cs, spi_sck, spi_mosi;
    logic              spi_miso, spi_miso_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata = 8'd0;
    logic              powered_down;
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
    logic              mem_wr;
    logic [7:0]        mem_wdata;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [7:0]  miso_exp_q[$];
    logic [31:0] rd_exp_q[$];
    logic [31:0] wr_exp_q[$];
    logic        mem_rd_prev = 1'b0;

    spi_flash_responder #(.ADDR_W(ADDR_W), .JEDEC_ID(24'hEF4016)) dut (
        .clk_48mhz   (clk_48mhz),
        .reset       (reset),
        .spi_cs      (spi_cs),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
`endif
        .powered_down(powered_down)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory returns the low address byte one clk after the read strobe.
    always @(posedge clk_48mhz) if (mem_rd) mem_rdata <= mem_addr[7:0];

    always @(negedge clk_48mhz) begin
        if (mem_rd === 1'b1) begin
            check_val("rd_single", 32'(mem_rd_prev), 32'd0);
            if (rd_exp_q.size() == 0) check_val("rd_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
            else check_val("rd_addr", 32'(mem_addr), rd_exp_q.pop_front());
        end
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
        if (mem_wr === 1'b1) begin
            if (wr_exp_q.size() == 0) check_val("wr_unexpected", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            else check_val("wr_addr_data", {mem_addr, mem_wdata}, wr_exp_q.pop_front());
        end
`endif
        mem_rd_prev = mem_rd;
    end

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            #HALF;
            spi_sck = 1'b1;
            rx[i] = spi_miso;
            #HALF;
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input logic chk_en, input logic [7:0] exp_miso,
                            input logic exp_oe);
        logic [7:0] rx;
        if (chk_en) miso_exp_q.push_back(exp_miso);
        check_val("miso_oe", 32'(spi_miso_oe), 32'(exp_oe));
        spi_bits(tx, 8, rx);
        if (chk_en) check_val("miso_byte", 32'(rx), 32'(miso_exp_q.pop_front()));
    endtask

    task automatic cs_low();
        @(negedge clk_48mhz);
        spi_cs = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF;
        spi_cs = 1'b1;
        repeat (8) @(negedge clk_48mhz);
    endtask

    initial begin
        reset    = 1'b1;
        spi_cs   = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk_48mhz);
        check_val("rst_miso", 32'(spi_miso), 32'd0);
        check_val("rst_oe", 32'(spi_miso_oe), 32'd0);
        check_val("rst_rd", 32'(mem_rd), 32'd0);
        check_val("rst_pd", 32'(powered_down), 32'd0);
        check_val("rst_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk_48mhz);
        check_val("idle_oe", 32'(spi_miso_oe), 32'd0);
        check_val("idle_pd", 32'(powered_down), 32'd0);

        // JEDEC ID, repeating after three bytes
        cs_low();
        spi_byte(8'h9F, 1'b0, 8'h00, 1'b0);
        spi_byte(8'h00, 1'b1, 8'hEF, 1'b1);
        spi_byte(8'h00, 1'b1, 8'h40, 1'b1);
        spi_byte(8'h00, 1'b1, 8'h16, 1'b1);
        spi_byte(8'h00, 1'b1, 8'hEF, 1'b1);
        cs_high();
        check_val("oe_after_cs", 32'(spi_miso_oe), 32'd0);

        // Read crossing a 256-byte boundary
        rd_exp_q.push_back(32'h0001FE);
        rd_exp_q.push_back(32'h0001FF);
        rd_exp_q.push_back(32'h000200);
        rd_exp_q.push_back(32'h000201);
        cs_low();
        spi_byte(8'h03, 1'b0, 8'h00, 1'b0);
        spi_byte(8'h00, 1'b0, 8'h00, 1'b0);
        spi_byte(8'h01, 1'b0, 8'h00, 1'b0);
        spi_byte(8'hFE, 1'b0, 8'h00, 1'b0);
        spi_byte(8'h00, 1'b1, 8'hFE, 1'b1);
        spi_byte(8'h00, 1'b1, 8'hFF, 1'b1);
        spi_byte(8'h00, 1'b1, 8'h00, 1'b1);
        cs_high();
        check_val("rd_q_drained1", rd_exp_q.size(), 32'd0);

        // Read wrapping the top of the address space
        rd_exp_q.push_back(32'hFFFFFF);
        rd_exp_q.push_back(32'h000000);
        rd_exp_q.push_back(32'h000001);
        cs_low();
        spi_byte(8'h03, 1'b0, 8'h00, 1'b0);
        spi_byte(8'hFF, 1'b0, 8'h00, 1'b0);
        spi_byte(8'hFF, 1'b0, 8'h00, 1'b0);
        spi_byte(8'hFF, 1'b0, 8'h00, 1'b0);
        spi_byte(8'h00, 1'b1, 8'hFF, 1'b1);
        spi_byte(8'h00, 1'b1, 8'h00, 1'b1);
        cs_high();
        check_val("rd_q_drained2", rd_exp_q.size(), 32'd0);

        // Deep power-down takes effect only at CS rise, and wakes on 0xAB
        cs_low();
        spi_byte(8'hB9, 1'b0, 8'h00, 1'b0);
        repeat (10) @(negedge clk_48mhz);
        check_val("pd_before_cs", 32'(powered_down), 32'd0);
        cs_high();
        check_val("pd_set", 32'(powered_down), 32'd1);
        cs_low();
        spi_byte(8'h9F, 1'b0, 8'h00, 1'b0);
        spi_byte(8'h00, 1'b1, 8'h00, 1'b0);
        cs_high();
        check_val("pd_hold", 32'(powered_down), 32'd1);
        cs_low();
        spi_byte(8'hAB, 1'b0, 8'h00, 1'b0);
        cs_high();
        check_val("pd_clear", 32'(powered_down), 32'd0);
        cs_low();
        spi_byte(8'h9F, 1'b0, 8'h00, 1'b0);
        spi_byte(8'h00, 1'b1, 8'hEF, 1'b1);
        cs_high();

        // Abort a read after 13 address bits: no read strobe, back to command decode
        begin
            logic [7:0] dummy;
            cs_low();
            spi_byte(8'h03, 1'b0, 8'h00, 1'b0);
            spi_bits(8'h00, 8, dummy);
            spi_bits(8'h01, 5, dummy);
            cs_high();
        end
        cs_low();
        spi_byte(8'h05, 1'b0, 8'h00, 1'b0);
        spi_byte(8'h00, 1'b1, 8'h00, 1'b1);
        spi_byte(8'h00, 1'b1, 8'h00, 1'b1);
        cs_high();

        // Write enable and page program
        cs_low();
        spi_byte(8'h06, 1'b0, 8'h00, 1'b0);
        cs_high();
        cs_low();
        spi_byte(8'h05, 1'b0, 8'h00, 1'b0);
`ifdef SPI_FLASH_RESPONDER_WRITE_EN
        spi_byte(8'h00, 1'b1, 8'h02, 1'b1);
        wr_exp_q.push_back({24'h0000FF, 8'hA5});
        wr_exp_q.push_back({24'h000000, 8'h5A});
`else
        spi_byte(8'h00, 1'b1, 8'h00, 1'b1);
`endif
        cs_high();
        cs_low();
        spi_byte(8'h02, 1'b0, 8'h00, 1'b0);
        spi_byte(8'h00, 1'b0, 8'h00, 1'b0);
        spi_byte(8'h00, 1'b0, 8'h00, 1'b0);
        spi_byte(8'hFF, 1'b0, 8'h00, 1'b0);
        spi_byte(8'hA5, 1'b0, 8'h00, 1'b0);
        spi_byte(8'h5A, 1'b0, 8'h00, 1'b0);
        cs_high();
        check_val("wr_q_drained", wr_exp_q.size(), 32'd0);
        cs_low();
        spi_byte(8'h05, 1'b0, 8'h00, 1'b0);
        spi_byte(8'h00, 1'b1, 8'h00, 1'b1);
        cs_high();
        check_val("rd_q_drained3", rd_exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
